// File: rtl/perf430_pkg.sv
// perf430_pkg: shared constants for the perf_counter block.
//   - register indices inside the 8-word window
//   - CTRL / STAT bit positions
//   - counter state encoding
//   - identification constant returned by the ID register
package perf430_pkg;

  // Register indices (per_addr[2:0])
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_STAT   = 3'd1;
  localparam logic [2:0] IDX_CNT_LO = 3'd2;
  localparam logic [2:0] IDX_CNT_HI = 3'd3;
  localparam logic [2:0] IDX_CMP_LO = 3'd4;
  localparam logic [2:0] IDX_CMP_HI = 3'd5;
  localparam logic [2:0] IDX_ID     = 3'd6;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_SRC     = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_CLR     = 3;
  localparam int CTRL_ONESHOT = 4;

  // STAT bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_RUN   = 2;

  localparam logic [15:0] PERF_ID = 16'h5043;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } perf_state_t;

endpackage

// File: rtl/perf_event_sync.sv
// perf_event_sync: brings the asynchronous event_in into the mclk domain
// and produces a one-cycle pulse for each rising edge.
//   mclk       - clock
//   reset_n    - asynchronous active-low reset
//   event_in   - external event, asynchronous to mclk
//   event_rise - one mclk-cycle pulse per synchronized rising edge
// Latency: an edge of event_in is captured by sync_q1 on the first rising
// mclk edge, reaches sync_q2 on the second; event_rise is high during the
// following cycle, so a consumer registers it on the third edge.
module perf_event_sync (
  input  logic mclk,
  input  logic reset_n,
  input  logic event_in,
  output logic event_rise
);

  logic sync_q1;
  logic sync_q2;
  logic edge_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q1 <= event_in;
      sync_q2 <= sync_q1;
      edge_q  <= sync_q2;
    end
  end

  assign event_rise = sync_q2 & ~edge_q;

endmodule

// File: rtl/perf_counter.sv
// perf_counter: 32-bit performance counter peripheral on a 16-bit
// word-addressed peripheral bus, with compare/overflow interrupt.
//   BASE_ADDR  - byte base address of the 16-byte register window
//   mclk       - clock, reset_n - asynchronous active-low reset
//   per_addr   - word address, per_din - write data
//   per_en     - access enable, per_we - byte write enables (0 = read)
//   dbg_freeze - holds the count while high
//   event_in   - asynchronous external event (counted when CTRL.SRC=1)
//   per_dout   - read data, zero when this block is not addressed
//   irq_perf   - level interrupt, IE & (MATCH | OVF)
//   dbg_state  - current counter state (perf_state_t encoding)
//
// Bus handshake: an access lasts one cycle with per_en high. A read
// (per_we == 0) returns data combinationally in that cycle; a write takes
// effect on the rising edge that ends the cycle. There is no stall.
module perf_counter
  import perf430_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        dbg_freeze,
  input  logic        event_in,
  output logic [15:0] per_dout,
  output logic        irq_perf,
  output logic [1:0]  dbg_state
);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       hit;
  logic [2:0] idx;
  logic       rd;
  logic       wr_lo;
  logic       wr_hi;

  assign hit   = per_en & (per_addr[13:3] == BASE_ADDR[14:4]);
  assign idx   = per_addr[2:0];
  assign rd    = hit & (per_we == 2'b00);
  assign wr_lo = hit & per_we[0];
  assign wr_hi = hit & per_we[1];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic        en_q, src_q, ie_q, oneshot_q;
  logic        match_q, ovf_q;
  logic [31:0] count_q;
  logic [15:0] shadow_q;
  logic [31:0] cmp_q;
  perf_state_t state_q, state_d;

  logic        event_rise;
  logic        clr_pulse;
  logic        w1c_match, w1c_ovf;
  logic        inc;
  logic [31:0] count_inc;
  logic        match_hit, ovf_hit;

  perf_event_sync u_sync (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .event_in   (event_in),
    .event_rise (event_rise)
  );

  // CLR is a strobe carried by the CTRL write itself; it is never stored.
  assign clr_pulse = wr_lo & (idx == IDX_CTRL) & per_din[CTRL_CLR];
  assign w1c_match = wr_lo & (idx == IDX_STAT) & per_din[STAT_MATCH];
  assign w1c_ovf   = wr_lo & (idx == IDX_STAT) & per_din[STAT_OVF];

  // CLR dominates an increment in the same cycle: the count lands on 0 and
  // that would-be increment raises no MATCH/OVF.
  assign inc = (state_q == ST_RUN) & ~dbg_freeze & ~clr_pulse &
               (src_q ? event_rise : 1'b1);
  assign count_inc = count_q + 32'd1;
  assign match_hit = inc & (count_inc == cmp_q);
  assign ovf_hit   = inc & (count_q == 32'hFFFF_FFFF);

  // CTRL: all defined bits live in the low byte.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      src_q     <= 1'b0;
      ie_q      <= 1'b0;
      oneshot_q <= 1'b0;
    end else if (wr_lo && idx == IDX_CTRL) begin
      en_q      <= per_din[CTRL_EN];
      src_q     <= per_din[CTRL_SRC];
      ie_q      <= per_din[CTRL_IE];
      oneshot_q <= per_din[CTRL_ONESHOT];
    end
  end

  // STAT flags: a set in the same cycle wins over write-1-to-clear.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      match_q <= match_hit | (match_q & ~w1c_match);
      ovf_q   <= ovf_hit   | (ovf_q   & ~w1c_ovf);
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr_pulse) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_inc;
    end
  end

  // Reading CNT_LO snapshots the upper half so a following CNT_HI read
  // forms a coherent 32-bit value even while the counter keeps running.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
    end else if (clr_pulse) begin
      shadow_q <= '0;
    end else if (rd && idx == IDX_CNT_LO) begin
      shadow_q <= count_q[31:16];
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_q <= '0;
    end else begin
      if (wr_lo && idx == IDX_CMP_LO) cmp_q[7:0]   <= per_din[7:0];
      if (wr_hi && idx == IDX_CMP_LO) cmp_q[15:8]  <= per_din[15:8];
      if (wr_lo && idx == IDX_CMP_HI) cmp_q[23:16] <= per_din[7:0];
      if (wr_hi && idx == IDX_CMP_HI) cmp_q[31:24] <= per_din[15:8];
    end
  end

  // ---------------------------------------------------------------------
  // Counter state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_RUN;
      ST_RUN: begin
        if (!en_q)                        state_d = ST_IDLE;
        else if (match_hit && oneshot_q)  state_d = ST_HALT;
      end
      ST_HALT: if (!en_q || clr_pulse) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------
  logic [15:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_CTRL: begin
        rd_data[CTRL_EN]      = en_q;
        rd_data[CTRL_SRC]     = src_q;
        rd_data[CTRL_IE]      = ie_q;
        rd_data[CTRL_ONESHOT] = oneshot_q;
      end
      IDX_STAT: begin
        rd_data[STAT_MATCH] = match_q;
        rd_data[STAT_OVF]   = ovf_q;
        rd_data[STAT_RUN]   = (state_q == ST_RUN);
      end
      IDX_CNT_LO: rd_data = count_q[15:0];
      IDX_CNT_HI: rd_data = shadow_q;
      IDX_CMP_LO: rd_data = cmp_q[15:0];
      IDX_CMP_HI: rd_data = cmp_q[31:16];
      IDX_ID:     rd_data = PERF_ID;
      default:    rd_data = '0;
    endcase
  end

  // The bus is OR-combined, so anything other than our own read is 0.
  // reset_n gates the read path so ID does not leak out during reset.
  assign per_dout = (rd && reset_n) ? rd_data : 16'h0000;
  assign irq_perf = ie_q & (match_q | ovf_q);

endmodule

// File: doc/perf_counter.md
PERF_COUNTER -- requirements
Module: perf_counter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h0190, byte base address of the 16-byte register window.
REQ-002 SHALL have port mclk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port per_addr, input, 14, peripheral word address.
REQ-005 SHALL have port per_din, input, 16, peripheral write data.
REQ-006 SHALL have port per_en, input, 1, peripheral access enable, active high.
REQ-007 SHALL have port per_we, input, 2, byte write enables: bit0 selects the low byte, bit1 the high byte.
REQ-008 SHALL have port dbg_freeze, input, 1, debug freeze that holds the count.
REQ-009 SHALL have port event_in, input, 1, external event, asynchronous to mclk.
REQ-010 SHALL have port per_dout, output, 16, read data, OR-combined onto the bus with the other peripherals.
REQ-011 SHALL have port irq_perf, output, 1, level interrupt request, active high.

Function
REQ-012 SHALL decode hit = per_en & (per_addr[13:3] == BASE_ADDR[14:4]), with register index per_addr[2:0].
REQ-013 SHALL drive per_dout combinationally in the access cycle when hit and per_we==0, and drive 16'h0000 otherwise.
REQ-014 SHALL apply writes on the clock edge ending the access, per byte according to per_we.
REQ-015 SHALL implement idx0 CTRL: bit0 EN, bit1 SRC (0 = mclk cycles, 1 = event edges), bit2 IE, bit3 CLR (write-1, self-clearing, reads 0), bit4 ONESHOT; all other bits read 0.
REQ-016 SHALL implement idx1 STAT: bit0 MATCH (write-1-to-clear), bit1 OVF (write-1-to-clear), bit2 RUN (read-only, 1 in state RUN).
REQ-017 SHALL implement idx2 CNT_LO as a read of count[15:0] that also latches count[31:16] into a shadow register.
REQ-018 SHALL implement idx3 CNT_HI as a read of the shadow register; writes to idx2/idx3 SHALL be ignored.
REQ-019 SHALL implement idx4/idx5 CMP_LO/CMP_HI as read/write halves of a 32-bit compare register.
REQ-020 SHALL implement idx6 ID as read-only 16'h5043; idx7 SHALL read 0 and ignore writes.
REQ-021 SHALL implement a state machine with states IDLE, RUN and HALT.
REQ-022 SHALL transition IDLE->RUN when EN=1, RUN->IDLE when EN=0, and RUN->HALT on a compare match with ONESHOT=1.
REQ-023 SHALL transition HALT->IDLE when EN is written 0, or on CLR.
REQ-024 SHALL increment count by 1 only in RUN with dbg_freeze=0, every cycle when SRC=0, or on each synchronized rising edge of event_in when SRC=1.
REQ-025 SHALL reflect an event_in edge in count 3 mclk cycles after the edge (2-flop synchronizer plus edge register).
REQ-026 SHALL wrap count from 32'hFFFFFFFF to 0 and set OVF in that cycle.
REQ-027 SHALL set MATCH in the cycle the incremented count equals CMP.
REQ-028 SHALL hold count unchanged in IDLE and HALT.
REQ-029 SHALL zero count and the shadow on CLR; CLR coinciding with an increment SHALL leave count 0.
REQ-030 SHALL give flag set priority over a simultaneous write-1-to-clear.
REQ-031 SHALL drive irq_perf = IE & (MATCH | OVF).

Reset
REQ-032 SHALL on reset_n low immediately clear CTRL, STAT flags, count, shadow, CMP and the synchronizer flops, and set the state to IDLE.
REQ-033 SHALL hold per_dout=0 and irq_perf=0 while in reset; reset asserted mid-count SHALL discard all state.

Structure
REQ-034 SHALL take register indices, CTRL/STAT bit positions, the state encoding and the ID constant from shared package perf430_pkg.
REQ-035 SHALL place the synchronizer and rising-edge detector in sub-module perf_event_sync.

Verification
REQ-036 SHALL verify: CMP=32'd100, CTRL=0x0015 -> MATCH and irq_perf set at the 100th increment, STAT.RUN drops, count stays 100.
REQ-037 SHALL verify: count preloaded near 32'hFFFFFFFE by running, SRC=0 -> wrap to 0, OVF=1; writing STAT=0x0002 clears it unless a new overflow occurs in the same cycle.
REQ-038 SHALL verify: SRC=1 with 5 event_in pulses, each 4 cycles wide -> count=5, each increment 3 cycles after its edge.
REQ-039 SHALL verify: read CNT_LO at count 0x0001FFFF, advance, then read CNT_HI -> 0x0001 returned from the shadow.
REQ-040 SHALL verify: dbg_freeze=1 for 10 cycles in RUN -> count unchanged; CLR during increment -> count 0.
REQ-041 SHALL verify: reset_n pulsed low mid-RUN -> all registers 0, ID still reads 16'h5043, per_dout=0 for non-hit addresses.
